// File: rtl/router_pkg.sv
// Shared constants and the check-accumulate function for the router register stage.
package router_pkg;
   localparam int CHK_XOR = 0;
   localparam int CHK_SUM = 1;
   localparam int DEF_DW  = 8;
   localparam int MAX_DW  = 64;

   // Works at MAX_DW; callers truncate to their DW, which yields sum mod 2^DW.
   function automatic logic [MAX_DW-1:0] chk_f(input logic [MAX_DW-1:0] acc,
                                               input logic [MAX_DW-1:0] x,
                                               input int                mode);
      if (mode == CHK_SUM) return acc + x;
      return acc ^ x;
   endfunction
endpackage

// File: rtl/router_reg_gen_if.sv
// FSM strobes, input byte stream and FIFO write bus of the router register stage.
interface router_reg_gen_if import router_pkg::*; #(
   parameter int DW         = DEF_DW,
   parameter int HOLD_DEPTH = 2
);
   localparam int CW = $clog2(HOLD_DEPTH + 1);

   logic          pkt_valid;
   logic [DW-1:0] din;
   logic          fifo_full;
   logic          detect_addr;
   logic          lfd_state;
   logic          ld_state;
   logic          laf_state;
   logic          full_state;
   logic          rst_int_reg;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          err;
   logic          parity_done;
   logic          low_pkt_valid;
   logic [CW-1:0] hold_count;
   logic          hold_ovf;

   modport master (
      output pkt_valid, din, fifo_full, detect_addr, lfd_state, ld_state,
             laf_state, full_state, rst_int_reg,
      input  dout, dout_valid, err, parity_done, low_pkt_valid, hold_count, hold_ovf
   );

   modport slave (
      input  pkt_valid, din, fifo_full, detect_addr, lfd_state, ld_state,
             laf_state, full_state, rst_int_reg,
      output dout, dout_valid, err, parity_done, low_pkt_valid, hold_count, hold_ovf
   );
endinterface

// File: rtl/router_hold_fifo.sv
// Small synchronous FIFO holding bytes (plus last tag) that arrive while the port FIFO is full.
// A push into a full buffer is dropped unless a pop happens in the same cycle.
module router_hold_fifo import router_pkg::*; #(
   parameter int  W     = DEF_DW + 1,
   parameter int  DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  head,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);
   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= nxt(wr_ptr);
         end
         if (do_pop) rd_ptr <= nxt(rd_ptr);
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end
endmodule

// File: rtl/router_reg_gen.sv
// Router input register stage: header capture, 1-cycle FIFO write path, packet check.
// While fifo_full is high bytes park in the hold buffer and drain in order once it drops.
module router_reg_gen import router_pkg::*; #(
   parameter int DW         = DEF_DW,
   parameter int HOLD_DEPTH = 2,
   parameter int CHK_MODE   = CHK_XOR
) (
   input logic             clk,
   input logic             rst,
   router_reg_gen_if.slave bus
);
   localparam int CW = $clog2(HOLD_DEPTH + 1);

   logic [DW-1:0] header;
   logic [DW-1:0] acc;
   logic [DW-1:0] ex_chk;
   logic [DW-1:0] dout_q;
   logic          dout_valid_q;
   logic          err_q;
   logic          parity_done_q;
   logic          low_pkt_valid_q;
   logic          hold_ovf_q;
   logic          chk_cap;
   logic          last_q;
   logic          is_chk;
   logic          wr;
   logic          wr_last;
   logic [DW-1:0] wr_dat;
   logic          push;
   logic          pop;
   logic [DW:0]   hold_head;
   logic [CW-1:0] hold_count;
   logic          hold_full;
   logic          hold_empty;

   // Only the first !pkt_valid byte in ld_state is the check byte.
   assign is_chk = bus.ld_state && !bus.pkt_valid && !chk_cap;

   router_hold_fifo #(.W(DW + 1), .DEPTH(HOLD_DEPTH)) u_hold (
      .clk   (clk),
      .rst   (rst),
      .clr   (bus.detect_addr),
      .push  (push),
      .pop   (pop),
      .wdata ({is_chk, bus.din}),
      .head  (hold_head),
      .count (hold_count),
      .full  (hold_full),
      .empty (hold_empty)
   );

   always_comb begin
      wr      = 1'b0;
      wr_last = 1'b0;
      wr_dat  = '0;
      push    = 1'b0;
      pop     = 1'b0;
      if (bus.lfd_state) begin
         wr     = 1'b1;
         wr_dat = header;
      end else if (bus.ld_state) begin
         push = bus.fifo_full || !hold_empty;
         if (!bus.fifo_full) begin
            wr = 1'b1;
            if (hold_empty) begin
               {wr_last, wr_dat} = {is_chk, bus.din};
            end else begin
               pop               = 1'b1;
               {wr_last, wr_dat} = hold_head;
            end
         end
      end else if (bus.laf_state && !bus.fifo_full && !hold_empty) begin
         wr                = 1'b1;
         pop               = 1'b1;
         {wr_last, wr_dat} = hold_head;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         header          <= '0;
         acc             <= '0;
         ex_chk          <= '0;
         dout_q          <= '0;
         dout_valid_q    <= 1'b0;
         err_q           <= 1'b0;
         parity_done_q   <= 1'b0;
         low_pkt_valid_q <= 1'b0;
         hold_ovf_q      <= 1'b0;
         chk_cap         <= 1'b0;
         last_q          <= 1'b0;
      end else begin
         if (bus.detect_addr && bus.pkt_valid) header <= bus.din;
         dout_valid_q <= wr;
         if (wr) dout_q <= wr_dat;
         if (bus.ld_state && !bus.pkt_valid) low_pkt_valid_q <= 1'b1;
         else if (bus.rst_int_reg)           low_pkt_valid_q <= 1'b0;
         if (bus.detect_addr) begin
            acc           <= '0;
            ex_chk        <= '0;
            parity_done_q <= 1'b0;
            err_q         <= 1'b0;
            hold_ovf_q    <= 1'b0;
            chk_cap       <= 1'b0;
            last_q        <= 1'b0;
         end else begin
            last_q <= wr && wr_last;
            if (bus.lfd_state && bus.pkt_valid)
               acc <= DW'(chk_f(MAX_DW'(acc), MAX_DW'(header), CHK_MODE));
            else if (bus.ld_state && bus.pkt_valid && !bus.full_state)
               acc <= DW'(chk_f(MAX_DW'(acc), MAX_DW'(bus.din), CHK_MODE));
            if (is_chk) begin
               ex_chk  <= bus.din;
               chk_cap <= 1'b1;
            end
            if (push && hold_full && !pop) hold_ovf_q <= 1'b1;
            // ex_chk is settled by now: the last byte left one cycle ago.
            if (last_q) begin
               parity_done_q <= 1'b1;
               err_q         <= (acc != ex_chk);
            end
         end
      end
   end

   assign bus.dout          = dout_q;
   assign bus.dout_valid    = dout_valid_q;
   assign bus.err           = err_q;
   assign bus.parity_done   = parity_done_q;
   assign bus.low_pkt_valid = low_pkt_valid_q;
   assign bus.hold_count    = hold_count;
   assign bus.hold_ovf      = hold_ovf_q;
endmodule

// File: tb/tb_router_reg_gen.sv
// Bench for router_reg_gen: XOR and SUM instances share stimulus; dout order is scoreboarded.
module tb_router_reg_gen;
   localparam logic [4:0] S_IDLE = 5'b00000;
   localparam logic [4:0] S_DA   = 5'b00001;
   localparam logic [4:0] S_LFD  = 5'b00010;
   localparam logic [4:0] S_LD   = 5'b00100;
   localparam logic [4:0] S_LAF  = 5'b01000;
   localparam logic [4:0] S_FULL = 5'b10000;

   logic       clk;
   logic       rst;
   logic       pkt_valid, fifo_full, detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
   logic [7:0] din;
   logic [7:0] exp_q [$];
   int         checks;
   int         errors;

   router_reg_gen_if #(.DW(8), .HOLD_DEPTH(2)) ifx ();
   router_reg_gen_if #(.DW(8), .HOLD_DEPTH(2)) ifs ();

   assign ifx.pkt_valid = pkt_valid;     assign ifs.pkt_valid = pkt_valid;
   assign ifx.din = din;                 assign ifs.din = din;
   assign ifx.fifo_full = fifo_full;     assign ifs.fifo_full = fifo_full;
   assign ifx.detect_addr = detect_addr; assign ifs.detect_addr = detect_addr;
   assign ifx.lfd_state = lfd_state;     assign ifs.lfd_state = lfd_state;
   assign ifx.ld_state = ld_state;       assign ifs.ld_state = ld_state;
   assign ifx.laf_state = laf_state;     assign ifs.laf_state = laf_state;
   assign ifx.full_state = full_state;   assign ifs.full_state = full_state;
   assign ifx.rst_int_reg = rst_int_reg; assign ifs.rst_int_reg = rst_int_reg;

   router_reg_gen #(.DW(8), .HOLD_DEPTH(2), .CHK_MODE(0)) dut_x (.clk(clk), .rst(rst), .bus(ifx));
   router_reg_gen #(.DW(8), .HOLD_DEPTH(2), .CHK_MODE(1)) dut_s (.clk(clk), .rst(rst), .bus(ifs));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1);
   end

   // Scoreboard: every written dout must match the oldest expected byte.
   always @(negedge clk) begin : mon
      logic [7:0] e;
      if (rst) begin
         checks++;
         if (ifx.dout_valid !== ifs.dout_valid) begin
            errors++;
            $display("FAIL valid_match: xor dout_valid %0b sum dout_valid %0b", ifx.dout_valid, ifs.dout_valid);
         end
         if (ifx.dout_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: got dout %0h expected no write", ifx.dout);
            end else begin
               e = exp_q.pop_front();
               if (ifx.dout !== e || ifs.dout !== e) begin
                  errors++;
                  $display("FAIL sb_dout: got %0h/%0h expected %0h", ifx.dout, ifs.dout, e);
               end
            end
         end
      end
   end

   function automatic logic [7:0] model(input int mode, input logic [7:0] h, p0, p1, p2, input int n);
      logic [7:0] pl [3];
      logic [7:0] a;
      pl = '{p0, p1, p2};
      a  = h;
      for (int i = 0; i < n; i++) a = (mode == 1) ? a + pl[i] : a ^ pl[i];
      return a;
   endfunction

   task automatic drive(input logic [7:0] d, input logic pv, input logic ff, input logic [4:0] st, input logic ri);
      din = d;
      pkt_valid = pv;
      fifo_full = ff;
      {full_state, laf_state, ld_state, lfd_state, detect_addr} = st;
      rst_int_reg = ri;
      @(posedge clk);
      #1;
   endtask

   task automatic send_pkt(input logic [7:0] hdr, p0, p1, p2, input int n, input logic [7:0] chk);
      logic [7:0] pl [3];
      pl = '{p0, p1, p2};
      drive(hdr, 1'b1, 1'b0, S_DA, 1'b0);
      exp_q.push_back(hdr);
      drive(8'h00, 1'b1, 1'b0, S_LFD, 1'b0);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(pl[i]);
         drive(pl[i], 1'b1, 1'b0, S_LD, 1'b0);
      end
      exp_q.push_back(chk);
      drive(chk, 1'b0, 1'b0, S_LD, 1'b1);
   endtask

   task automatic test_reset;
      rst = 1'b0;
      drive(8'hAA, 1'b1, 1'b0, S_LFD, 1'b0);
      drive(8'h55, 1'b1, 1'b0, S_IDLE, 1'b0);
      checks++;
      if ({ifx.dout, ifx.dout_valid, ifx.err, ifx.parity_done, ifx.low_pkt_valid, ifx.hold_count, ifx.hold_ovf} !== 15'h0) begin
         errors++;
         $display("FAIL reset_x: got dout %0h valid %0b pd %0b", ifx.dout, ifx.dout_valid, ifx.parity_done);
      end
      checks++;
      if ({ifs.dout, ifs.dout_valid, ifs.err, ifs.parity_done, ifs.low_pkt_valid, ifs.hold_count, ifs.hold_ovf} !== 15'h0) begin
         errors++;
         $display("FAIL reset_s: got dout %0h valid %0b pd %0b", ifs.dout, ifs.dout_valid, ifs.parity_done);
      end
      rst = 1'b1;
   endtask

   task automatic test_xor_clean;
      send_pkt(8'h0C, 8'h11, 8'h22, 8'h33, 3, 8'h0C);
      checks++;
      if (ifx.low_pkt_valid !== 1'b1 || ifx.parity_done !== 1'b0) begin
         errors++;
         $display("FAIL clean_lpv_set: got lpv %0b pd %0b expected 1 0", ifx.low_pkt_valid, ifx.parity_done);
      end
      drive(8'h00, 1'b0, 1'b0, S_IDLE, 1'b1);
      checks++;
      if (ifx.parity_done !== 1'b1 || ifx.err !== 1'b0) begin
         errors++;
         $display("FAIL clean_x: got pd %0b err %0b expected 1 0", ifx.parity_done, ifx.err);
      end
      checks++;
      if (ifs.parity_done !== 1'b1 || ifs.err !== 1'b1) begin
         errors++;
         $display("FAIL clean_s: got pd %0b err %0b expected 1 1", ifs.parity_done, ifs.err);
      end
      checks++;
      if (ifx.low_pkt_valid !== 1'b0) begin
         errors++;
         $display("FAIL clean_lpv_clr: got %0b expected 0", ifx.low_pkt_valid);
      end
      drive(8'h00, 1'b0, 1'b0, S_IDLE, 1'b0);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL clean_drain: got %0d pending expected 0", exp_q.size());
      end
   endtask

   task automatic test_xor_err;
      send_pkt(8'h0C, 8'h11, 8'h22, 8'h33, 3, 8'h0D);
      drive(8'h00, 1'b0, 1'b0, S_IDLE, 1'b1);
      checks++;
      if (ifx.parity_done !== 1'b1 || ifx.err !== 1'b1 || ifs.err !== 1'b1) begin
         errors++;
         $display("FAIL err_set: got pd %0b errx %0b errs %0b expected 1 1 1", ifx.parity_done, ifx.err, ifs.err);
      end
      drive(8'h00, 1'b0, 1'b0, S_DA, 1'b0);
      checks++;
      if (ifx.parity_done !== 1'b0 || ifx.err !== 1'b0 || ifs.parity_done !== 1'b0 || ifs.err !== 1'b0) begin
         errors++;
         $display("FAIL err_clear: got pd %0b err %0b expected 0 0", ifx.parity_done, ifx.err);
      end
   endtask

   task automatic test_sum;
      logic [7:0] hv [3];
      logic [7:0] p0v [3];
      logic [7:0] cv [3];
      int         nv [3];
      hv  = '{8'h0C, 8'h0C, 8'hFF};
      p0v = '{8'h11, 8'h11, 8'h02};
      cv  = '{8'h72, 8'h73, 8'h01};
      nv  = '{3, 3, 1};
      for (int k = 0; k < 3; k++) begin
         send_pkt(hv[k], p0v[k], 8'h22, 8'h33, nv[k], cv[k]);
         drive(8'h00, 1'b0, 1'b0, S_IDLE, 1'b1);
         checks++;
         if (ifs.parity_done !== 1'b1 || ifs.err !== (cv[k] != model(1, hv[k], p0v[k], 8'h22, 8'h33, nv[k]))) begin
            errors++;
            $display("FAIL sum_err_%0d: got pd %0b err %0b", k, ifs.parity_done, ifs.err);
         end
         checks++;
         if (ifx.err !== (cv[k] != model(0, hv[k], p0v[k], 8'h22, 8'h33, nv[k]))) begin
            errors++;
            $display("FAIL sum_xor_err_%0d: got err %0b", k, ifx.err);
         end
      end
   endtask

   task automatic test_fifo_full;
      drive(8'h0C, 1'b1, 1'b0, S_DA, 1'b0);
      exp_q.push_back(8'h0C); drive(8'h00, 1'b1, 1'b0, S_LFD, 1'b0);
      exp_q.push_back(8'h11); drive(8'h11, 1'b1, 1'b0, S_LD, 1'b0);
      exp_q.push_back(8'h22); drive(8'h22, 1'b1, 1'b1, S_LD, 1'b0);
      checks++;
      if (ifx.hold_count !== 2'd1 || ifx.dout_valid !== 1'b0 || ifx.dout !== 8'h11) begin
         errors++;
         $display("FAIL full_hold1: got cnt %0d valid %0b dout %0h expected 1 0 11", ifx.hold_count, ifx.dout_valid, ifx.dout);
      end
      exp_q.push_back(8'h33); drive(8'h33, 1'b1, 1'b1, S_LD, 1'b0);
      drive(8'h33, 1'b1, 1'b1, S_FULL, 1'b0);
      checks++;
      if (ifx.hold_count !== 2'd2 || ifx.dout_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_hold2: got cnt %0d valid %0b expected 2 0", ifx.hold_count, ifx.dout_valid);
      end
      drive(8'h00, 1'b1, 1'b0, S_LAF, 1'b0);
      checks++;
      if (ifx.hold_count !== 2'd1 || ifx.dout_valid !== 1'b1) begin
         errors++;
         $display("FAIL full_laf1: got cnt %0d valid %0b expected 1 1", ifx.hold_count, ifx.dout_valid);
      end
      drive(8'h00, 1'b1, 1'b0, S_LAF, 1'b0);
      exp_q.push_back(8'h0C); drive(8'h0C, 1'b0, 1'b0, S_LD, 1'b1);
      drive(8'h00, 1'b0, 1'b0, S_IDLE, 1'b1);
      checks++;
      if (ifx.parity_done !== 1'b1 || ifx.err !== 1'b0 || ifx.hold_ovf !== 1'b0 || ifx.hold_count !== 2'd0) begin
         errors++;
         $display("FAIL full_done: got pd %0b err %0b ovf %0b cnt %0d expected 1 0 0 0", ifx.parity_done, ifx.err, ifx.hold_ovf, ifx.hold_count);
      end
   endtask

   task automatic test_overflow;
      drive(8'h0C, 1'b1, 1'b0, S_DA, 1'b0);
      exp_q.push_back(8'h0C); drive(8'h00, 1'b1, 1'b0, S_LFD, 1'b0);
      exp_q.push_back(8'h11); drive(8'h11, 1'b1, 1'b0, S_LD, 1'b0);
      exp_q.push_back(8'h22); drive(8'h22, 1'b1, 1'b1, S_LD, 1'b0);
      exp_q.push_back(8'h33); drive(8'h33, 1'b1, 1'b1, S_LD, 1'b0);
      drive(8'h0C, 1'b0, 1'b1, S_LD, 1'b1);
      checks++;
      if (ifx.hold_ovf !== 1'b1 || ifx.hold_count !== 2'd2) begin
         errors++;
         $display("FAIL ovf_set: got ovf %0b cnt %0d expected 1 2", ifx.hold_ovf, ifx.hold_count);
      end
      drive(8'h00, 1'b0, 1'b1, S_FULL, 1'b0);
      for (int i = 0; i < 3; i++) drive(8'h00, 1'b0, 1'b0, S_LAF, 1'b0);
      drive(8'h00, 1'b0, 1'b0, S_IDLE, 1'b0);
      drive(8'h00, 1'b0, 1'b0, S_IDLE, 1'b0);
      checks++;
      if (ifx.parity_done !== 1'b0 || ifs.parity_done !== 1'b0 || ifx.hold_count !== 2'd0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL ovf_no_done: got pd %0b cnt %0d pending %0d expected 0 0 0", ifx.parity_done, ifx.hold_count, exp_q.size());
      end
      drive(8'h00, 1'b0, 1'b0, S_DA, 1'b0);
      checks++;
      if (ifx.hold_ovf !== 1'b0 || ifx.hold_count !== 2'd0) begin
         errors++;
         $display("FAIL ovf_clear: got ovf %0b cnt %0d expected 0 0", ifx.hold_ovf, ifx.hold_count);
      end
   endtask

   task automatic test_push_pop_full;
      drive(8'h0C, 1'b1, 1'b0, S_DA, 1'b0);
      exp_q.push_back(8'h0C); drive(8'h00, 1'b1, 1'b0, S_LFD, 1'b0);
      exp_q.push_back(8'h11); drive(8'h11, 1'b1, 1'b0, S_LD, 1'b0);
      exp_q.push_back(8'h22); drive(8'h22, 1'b1, 1'b1, S_LD, 1'b0);
      exp_q.push_back(8'h33); drive(8'h33, 1'b1, 1'b1, S_LD, 1'b0);
      exp_q.push_back(8'h44); drive(8'h44, 1'b1, 1'b0, S_LD, 1'b0);
      checks++;
      if (ifx.hold_count !== 2'd2 || ifx.hold_ovf !== 1'b0 || ifx.dout_valid !== 1'b1) begin
         errors++;
         $display("FAIL pp_full: got cnt %0d ovf %0b valid %0b expected 2 0 1", ifx.hold_count, ifx.hold_ovf, ifx.dout_valid);
      end
      // 0C^11^22^33^44 = 48 (xor); the sum is B6, so only the SUM instance flags.
      exp_q.push_back(8'h48); drive(8'h48, 1'b0, 1'b0, S_LD, 1'b1);
      drive(8'h00, 1'b0, 1'b0, S_LAF, 1'b0);
      drive(8'h00, 1'b0, 1'b0, S_LAF, 1'b0);
      checks++;
      if (ifx.parity_done !== 1'b0 || ifx.hold_count !== 2'd0) begin
         errors++;
         $display("FAIL pp_early: got pd %0b cnt %0d expected 0 0", ifx.parity_done, ifx.hold_count);
      end
      drive(8'h00, 1'b0, 1'b0, S_IDLE, 1'b1);
      checks++;
      if (ifx.parity_done !== 1'b1 || ifx.err !== 1'b0 || ifs.err !== 1'b1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL pp_done: got pd %0b errx %0b errs %0b pending %0d expected 1 0 1 0", ifx.parity_done, ifx.err, ifs.err, exp_q.size());
      end
   endtask

   task automatic test_mid_reset;
      drive(8'h0C, 1'b1, 1'b0, S_DA, 1'b0);
      exp_q.push_back(8'h0C); drive(8'h00, 1'b1, 1'b0, S_LFD, 1'b0);
      exp_q.push_back(8'h11); drive(8'h11, 1'b1, 1'b0, S_LD, 1'b0);
      exp_q.push_back(8'h22); drive(8'h22, 1'b1, 1'b1, S_LD, 1'b0);
      checks++;
      if (ifx.hold_count !== 2'd1) begin
         errors++;
         $display("FAIL mr_hold: got cnt %0d expected 1", ifx.hold_count);
      end
      rst = 1'b0;
      exp_q.delete();
      drive(8'h33, 1'b1, 1'b0, S_LD, 1'b0);
      checks++;
      if ({ifx.dout, ifx.dout_valid, ifx.err, ifx.parity_done, ifx.low_pkt_valid, ifx.hold_count, ifx.hold_ovf} !== 15'h0) begin
         errors++;
         $display("FAIL mr_outputs: got dout %0h valid %0b cnt %0d expected all 0", ifx.dout, ifx.dout_valid, ifx.hold_count);
      end
      rst = 1'b1;
      send_pkt(8'h0C, 8'h11, 8'h22, 8'h33, 3, 8'h0C);
      drive(8'h00, 1'b0, 1'b0, S_IDLE, 1'b1);
      checks++;
      if (ifx.parity_done !== 1'b1 || ifx.err !== 1'b0) begin
         errors++;
         $display("FAIL mr_clean: got pd %0b err %0b expected 1 0", ifx.parity_done, ifx.err);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      din = 8'h00;
      {pkt_valid, fifo_full, detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = 8'h00;
      test_reset();
      test_xor_clean();
      test_xor_err();
      test_sum();
      test_fifo_full();
      test_overflow();
      test_push_pop_full();
      test_mid_reset();
      drive(8'h00, 1'b0, 1'b0, S_IDLE, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/router_reg_gen.md
Name: router_reg_gen

Overview:
- Parametrised next-generation router input register stage.
- Sits between the router FSM and the per-port FIFOs; consumes the FSM state strobes (detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg).
- Captures the header, forwards payload to the FIFO write bus and computes the packet check value against the trailing check byte.
- New in this generation: configurable data width, a multi-entry hold buffer for bytes arriving while the FIFO is full, a selectable check mode (XOR parity or additive checksum), and an explicit output-valid strobe plus overflow flag.

Parameters:
- DW, 8, data/header/check width in bits (>=8).
- HOLD_DEPTH, 2, hold buffer entries (1..8); HOLD_DEPTH=1 reproduces single-register behaviour.
- CHK_MODE, 0, 0 = XOR parity; 1 = sum mod 2^DW.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-low reset.
- pkt_valid  in  1  din carries header/payload; low on the check byte.
- din  in  DW  input byte.
- fifo_full  in  1  selected FIFO cannot accept a write this cycle.
- detect_addr  in  1  FSM in DECODE_ADDRESS.
- lfd_state  in  1  FSM in LOAD_FIRST_DATA.
- ld_state  in  1  FSM in LOAD_DATA.
- laf_state  in  1  FSM in LOAD_AFTER_FULL.
- full_state  in  1  FSM in FIFO_FULL_STATE.
- rst_int_reg  in  1  clear low_pkt_valid.
- dout  out  DW  FIFO write data.
- dout_valid  out  1  dout written this cycle (FIFO write enable qualifier).
- err  out  1  check mismatch; valid while parity_done=1.
- parity_done  out  1  check byte has left the block.
- low_pkt_valid  out  1  pkt_valid fell during ld_state.
- hold_count  out  $clog2(HOLD_DEPTH+1)  hold buffer occupancy.
- hold_ovf  out  1  sticky: a byte was pushed into a full hold buffer.

Behaviour:
- Reset (rst=0 at posedge) overrides everything. All outputs, header, accumulator, ex_chk, hold buffer and pointers clear to 0.
- header <= din when detect_addr && pkt_valid.
- detect_addr also clears: accumulator, ex_chk, parity_done, err, hold_ovf, hold buffer.
- Accumulate function f: CHK_MODE 0 gives acc^x; CHK_MODE 1 gives (acc+x) mod 2^DW.
- Accumulator updates:
  - lfd_state && pkt_valid: acc <= f(acc, header).
  - ld_state && pkt_valid && !full_state: acc <= f(acc, din).
  - Otherwise acc holds.
- Check byte = first din with ld_state && !pkt_valid. It is captured into ex_chk on that cycle regardless of fifo_full. The byte also travels the data path tagged "last".
- Data path, registered, one cycle latency. dout_valid=1 exactly on cycles dout was written, else 0; dout holds its value otherwise.
  - lfd_state: dout <= header.
  - ld_state, !fifo_full, hold empty: dout <= din.
  - ld_state, !fifo_full, hold non-empty: dout <= hold head (pop) and din pushed (ordering preserved).
  - ld_state && fifo_full: push din.
  - laf_state && !fifo_full && hold non-empty: pop to dout.
  - laf_state && fifo_full: no change.
- Push when hold_count==HOLD_DEPTH: byte dropped, hold_ovf <= 1. The pop side is unaffected.
- Simultaneous push and pop when full: legal, count unchanged, no overflow.
- low_pkt_valid: set on ld_state && !pkt_valid. Otherwise cleared by rst_int_reg. Set wins if both occur in the same cycle.
- Completion: the cycle after a "last"-tagged byte is written to dout, parity_done <= 1 and err <= (acc != ex_chk). Both hold until detect_addr or reset.
- A check byte never reached dout (hold overflow) means parity_done never rises. The FSM recovers via the next detect_addr.
- State strobes are mutually exclusive by FSM contract. If more than one is asserted, priority is lfd > ld > laf for the data path.
- Reset mid-packet discards the packet; the next accepted header starts clean.

Decomposition:
- Package router_pkg:
  - CHK_XOR/CHK_SUM constants.
  - Default DW.
  - The chk_f function, shared with a future checker.
- One sub-module: router_hold_fifo. It is a small synchronous FIFO of DW+1 bits (data+last tag) with push/pop/count/full/empty, sync active-low reset, and clear on detect_addr.

Test Plan:
- XOR, HOLD_DEPTH=2: header 0x0C, payload 0x11,0x22,0x33, check 0x0C, fifo_full=0 -> dout sequence 0x0C,0x11,0x22,0x33,0x0C each with dout_valid=1; parity_done=1 one cycle after the check byte; err=0.
- Same packet with check byte 0x0D -> parity_done=1, err=1; both clear on the next detect_addr.
- CHK_MODE=1: header 0x0C, payload 0x11,0x22,0x33, check 0x72 -> err=0; check 0x73 -> err=1. Also: header 0xFF, payload 0x02, check 0x01 -> err=0 (wrap-around).
- fifo_full held high during payload 0x22,0x33 -> hold_count reaches 2, no dout_valid. After release in laf_state, dout 0x22 then 0x33 in order; hold_ovf=0.
- HOLD_DEPTH=2, fifo_full high across 0x22,0x33,check -> third push dropped, hold_ovf=1, parity_done stays 0. Then detect_addr -> hold_ovf=0, hold_count=0.
- rst=0 asserted mid-payload with hold_count=1 -> next cycle all outputs 0. A subsequent clean packet passes with err=0.
